// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM:
// opcodes, state codes, datapath select codes and the strobe bundle.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_BEQ      = 4'd9,
        S_JUMP     = 4'd10,
        S_IMM_EX   = 4'd11,
        S_IMM_WB   = 4'd12
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI) ||
               (op == OP_ORI);
    endfunction

endpackage

// File: rtl/mc_perf_counters.sv
// Cycle and retired-instruction counters for the control FSM.
// Only present when MC_PERF_CNT_EN is defined.
`ifdef MC_PERF_CNT_EN
module mc_perf_counters
    import mc_pkg::*;
#(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  state_t            state,
    input  state_t            nxt,
    output logic [PERF_W-1:0] cyc_cnt,
    output logic [PERF_W-1:0] instr_cnt
);

    logic retire;

    // Waiting in FETCH or leaving IDLE is not a retirement.
    assign retire = (state != S_IDLE) && (state != S_FETCH) &&
                    (nxt == S_FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt   <= '0;
            instr_cnt <= '0;
        end else begin
            if (state != S_IDLE) cyc_cnt <= cyc_cnt + 1'b1;
            if (retire) instr_cnt <= instr_cnt + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM with memory-ready handshake.
// MC_PERF_CNT_EN adds cyc_cnt / instr_cnt performance counters.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 2,
    parameter int STATE_W = 4,
    parameter int PERF_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_o
`ifdef MC_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]  cyc_cnt,
    output logic [PERF_W-1:0]  instr_cnt
`endif
);

    state_t     state;
    state_t     nxt;
    ctrl_t      c;
    logic [5:0] op;
    logic       is_mem;
    logic       is_imm;

    assign op     = 6'(opcode);
    assign is_mem = (op == OP_LW) || (op == OP_SW);
    assign is_imm = (op == OP_ADDI) || (op == OP_ORI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:     nxt = S_FETCH;
            S_FETCH:    if (mem_ready) nxt = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    is_mem:           nxt = S_MEMADR;
                    (op == OP_RTYPE): nxt = S_RTYPE_EX;
                    (op == OP_BEQ):   nxt = S_BEQ;
                    (op == OP_J):     nxt = S_JUMP;
                    is_imm:           nxt = S_IMM_EX;
                    default:          nxt = S_FETCH;
                endcase
            end
            S_MEMADR:   nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    if (mem_ready) nxt = S_MEMWB;
            S_MEMWB:    nxt = S_FETCH;
            S_MEMWR:    if (mem_ready) nxt = S_FETCH;
            S_RTYPE_EX: nxt = S_RTYPE_WB;
            S_RTYPE_WB: nxt = S_FETCH;
            S_BEQ:      nxt = S_FETCH;
            S_JUMP:     nxt = S_FETCH;
            S_IMM_EX:   nxt = S_IMM_WB;
            S_IMM_WB:   nxt = S_FETCH;
            default:    nxt = S_IDLE;
        endcase
    end

    always_comb begin
        c = '0;
        unique case (state)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_source = PCS_ALU;
                c.ir_write  = mem_ready;
                c.pc_write  = mem_ready;
            end
            S_DECODE: begin
                c.alu_src_b  = SRCB_IMM_SH;
                c.alu_op     = ALU_ADD;
                c.illegal_op = !op_legal(op);
            end
            S_MEMADR, S_IMM_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = (state == S_IMM_EX && op == OP_ORI) ?
                              ALU_OR : ALU_ADD;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_RTYPE_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_RT;
                c.alu_op    = ALU_FUNCT;
            end
            S_RTYPE_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_RT;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCS_ALUOUT;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCS_JUMP;
            end
            S_IMM_WB: c.reg_write = 1'b1;
            default: ;
        endcase
    end

    assign pc_write      = c.pc_write;
    assign pc_write_cond = c.pc_write_cond;
    assign iord          = c.iord;
    assign mem_read      = c.mem_read;
    assign mem_write     = c.mem_write;
    assign ir_write      = c.ir_write;
    assign mem_to_reg    = c.mem_to_reg;
    assign reg_write     = c.reg_write;
    assign reg_dst       = c.reg_dst;
    assign alu_src_a     = c.alu_src_a;
    assign alu_src_b     = c.alu_src_b;
    assign alu_op        = ALUOP_W'(c.alu_op);
    assign pc_source     = c.pc_source;
    assign illegal_op    = c.illegal_op;
    assign state_o       = STATE_W'(state);

`ifdef MC_PERF_CNT_EN
    mc_perf_counters #(
        .PERF_W(PERF_W)
    ) u_perf (
        .clk      (clk),
        .rst_n    (rst_n),
        .state    (state),
        .nxt      (nxt),
        .cyc_cnt  (cyc_cnt),
        .instr_cnt(instr_cnt)
    );
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
// Perf counter checks are built only with MC_PERF_CNT_EN.
module tb_multicycle_control;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, iord, mem_read, mem_write;
    logic        ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic        illegal_op;
    logic [3:0]  state_o;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cyc_cnt, instr_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // pcw pcwc iord mrd mwr irw m2r rw rdst srca srcb aluop pcs ill
    logic [16:0] sig;
    assign sig = {pc_write, pc_write_cond, iord, mem_read, mem_write,
                  ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a,
                  alu_src_b, alu_op, pc_source, illegal_op};

    localparam logic [16:0] V_ZERO   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] V_FETCH  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] V_FWAIT  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] V_DEC    = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] V_DECILL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] V_MADR   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] V_MRD    = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] V_MWB    = 17'b0_0_0_0_0_0_1_1_0_0_00_00_00_0;
    localparam logic [16:0] V_MWR    = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] V_REX    = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] V_RWB    = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] V_BEQ    = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] V_JUMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] V_ADDI   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] V_ORI    = 17'b0_0_0_0_0_0_0_0_0_1_10_11_00_0;
    localparam logic [16:0] V_IWB    = 17'b0_0_0_0_0_0_0_1_0_0_00_00_00_0;

    multicycle_control dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .iord         (iord),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .mem_to_reg   (mem_to_reg),
        .reg_write    (reg_write),
        .reg_dst      (reg_dst),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .pc_source    (pc_source),
        .illegal_op   (illegal_op),
        .state_o      (state_o)
`ifdef MC_PERF_CNT_EN
        ,
        .cyc_cnt      (cyc_cnt),
        .instr_cnt    (instr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'b000000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (state_o !== 4'd0) begin
            bad++;
            $display("FAIL reset state got=%0d want=0", state_o);
        end
        total++;
        if (sig !== V_ZERO) begin
            bad++;
            $display("FAIL reset outs got=%b want=%b", sig, V_ZERO);
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (state_o !== 4'd1) begin
            bad++;
            $display("FAIL reset_fetch state got=%0d want=1", state_o);
        end
        total++;
        if (sig !== V_FETCH) begin
            bad++;
            $display("FAIL reset_fetch outs got=%b want=%b", sig, V_FETCH);
        end
    endtask

    task automatic test_lw();
        logic [3:0]  es [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        logic [16:0] ev [5] = '{V_FETCH, V_DEC, V_MADR, V_MRD, V_MWB};
        opcode = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'b1;
            @(negedge clk);
            total++;
            if (state_o !== es[i]) begin
                bad++;
                $display("FAIL lw state[%0d] got=%0d want=%0d", i, state_o, es[i]);
            end
            total++;
            if (sig !== ev[i]) begin
                bad++;
                $display("FAIL lw outs[%0d] got=%b want=%b", i, sig, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_wait();
        logic        mr [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0]  es [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5};
        logic [16:0] ev [7] = '{V_FETCH, V_DEC, V_MADR, V_MRD, V_MRD,
                                V_MRD, V_MWB};
        opcode = 6'b100011;
        for (int i = 0; i < 7; i++) begin
            mem_ready = mr[i];
            @(negedge clk);
            total++;
            if (state_o !== es[i]) begin
                bad++;
                $display("FAIL lw_wait state[%0d] got=%0d want=%0d", i, state_o, es[i]);
            end
            total++;
            if (sig !== ev[i]) begin
                bad++;
                $display("FAIL lw_wait outs[%0d] got=%b want=%b", i, sig, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw();
        logic        mr [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0]  es [8] = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd6, 4'd6, 4'd6, 4'd6};
        logic [16:0] ev [8] = '{V_FWAIT, V_FETCH, V_DEC, V_MADR, V_MWR,
                                V_MWR, V_MWR, V_MWR};
        opcode = 6'b101011;
        for (int i = 0; i < 8; i++) begin
            mem_ready = mr[i];
            @(negedge clk);
            total++;
            if (state_o !== es[i]) begin
                bad++;
                $display("FAIL sw state[%0d] got=%0d want=%0d", i, state_o, es[i]);
            end
            total++;
            if (sig !== ev[i]) begin
                bad++;
                $display("FAIL sw outs[%0d] got=%b want=%b", i, sig, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_imm();
        logic [5:0]  ops [2] = '{6'b001101, 6'b001000};
        logic [16:0] exv [2] = '{V_ORI, V_ADDI};
        logic [3:0]  es [4] = '{4'd1, 4'd2, 4'd11, 4'd12};
        logic [16:0] ev [4];
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k];
            ev = '{V_FETCH, V_DEC, exv[k], V_IWB};
            for (int i = 0; i < 4; i++) begin
                mem_ready = 1'b1;
                @(negedge clk);
                total++;
                if (state_o !== es[i]) begin
                    bad++;
                    $display("FAIL imm%0d state[%0d] got=%0d want=%0d", k, i, state_o, es[i]);
                end
                total++;
                if (sig !== ev[i]) begin
                    bad++;
                    $display("FAIL imm%0d outs[%0d] got=%b want=%b", k, i, sig, ev[i]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_illegal();
        logic [3:0]  es [2] = '{4'd1, 4'd2};
        logic [16:0] ev [2] = '{V_FETCH, V_DECILL};
        opcode = 6'b111111;
        for (int i = 0; i < 2; i++) begin
            mem_ready = 1'b1;
            @(negedge clk);
            total++;
            if (state_o !== es[i]) begin
                bad++;
                $display("FAIL illegal state[%0d] got=%0d want=%0d", i, state_o, es[i]);
            end
            total++;
            if (sig !== ev[i]) begin
                bad++;
                $display("FAIL illegal outs[%0d] got=%b want=%b", i, sig, ev[i]);
            end
            @(posedge clk); #1;
        end
        total++;
        if (state_o !== 4'd1 || illegal_op !== 1'b0) begin
            bad++;
            $display("FAIL illegal_after state=%0d ill=%b want=1,0", state_o, illegal_op);
        end
    endtask

    task automatic test_mid_reset();
        opcode    = 6'b100011;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b0;
        total++;
        if (state_o !== 4'd4) begin
            bad++;
            $display("FAIL midrst_pre state got=%0d want=4", state_o);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (state_o !== 4'd0) begin
            bad++;
            $display("FAIL midrst_async state got=%0d want=0", state_o);
        end
        total++;
        if (sig !== V_ZERO) begin
            bad++;
            $display("FAIL midrst_async outs got=%b want=%b", sig, V_ZERO);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (state_o !== 4'd1) begin
            bad++;
            $display("FAIL midrst_resume state got=%0d want=1", state_o);
        end
    endtask

    task automatic test_beq();
        logic [3:0]  es [3] = '{4'd1, 4'd2, 4'd9};
        logic [16:0] ev [3] = '{V_FETCH, V_DEC, V_BEQ};
        opcode = 6'b000100;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            @(negedge clk);
            total++;
            if (state_o !== es[i]) begin
                bad++;
                $display("FAIL beq state[%0d] got=%0d want=%0d", i, state_o, es[i]);
            end
            total++;
            if (sig !== ev[i]) begin
                bad++;
                $display("FAIL beq outs[%0d] got=%b want=%b", i, sig, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jump();
        logic [3:0]  es [3] = '{4'd1, 4'd2, 4'd10};
        logic [16:0] ev [3] = '{V_FETCH, V_DEC, V_JUMP};
        opcode = 6'b000010;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            @(negedge clk);
            total++;
            if (state_o !== es[i]) begin
                bad++;
                $display("FAIL jump state[%0d] got=%0d want=%0d", i, state_o, es[i]);
            end
            total++;
            if (sig !== ev[i]) begin
                bad++;
                $display("FAIL jump outs[%0d] got=%b want=%b", i, sig, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        logic [3:0]  es [4] = '{4'd1, 4'd2, 4'd7, 4'd8};
        logic [16:0] ev [4] = '{V_FETCH, V_DEC, V_REX, V_RWB};
        opcode = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1;
            @(negedge clk);
            total++;
            if (state_o !== es[i]) begin
                bad++;
                $display("FAIL rtype state[%0d] got=%0d want=%0d", i, state_o, es[i]);
            end
            total++;
            if (sig !== ev[i]) begin
                bad++;
                $display("FAIL rtype outs[%0d] got=%b want=%b", i, sig, ev[i]);
            end
            @(posedge clk); #1;
        end
        total++;
        if (state_o !== 4'd1) begin
            bad++;
            $display("FAIL rtype_after state got=%0d want=1", state_o);
        end
    endtask

`ifdef MC_PERF_CNT_EN
    task automatic test_perf();
        total++;
        if (instr_cnt !== 32'd3) begin
            bad++;
            $display("FAIL perf instr_cnt got=%0d want=3", instr_cnt);
        end
        total++;
        if (cyc_cnt !== 32'd10) begin
            bad++;
            $display("FAIL perf cyc_cnt got=%0d want=10", cyc_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lw();
        test_lw_wait();
        test_sw();
        test_imm();
        test_illegal();
        test_mid_reset();
        test_beq();
        test_jump();
        test_rtype();
`ifdef MC_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
